dlock_keyer: RTL and testbench
==============================

# dlock_keyer

Serial code transmitter for the team's digital-lock receiver (`dlock`). It accepts a parallel code word with a one-cycle start request, resets the lock through its active-low clear line, and shifts the code out MSB-first, one bit per clock. It then watches the lock's `unlock` output and retries a bounded number of times before reporting pass or fail. It sits between a keypad/host controller and the lock, as the initiator end of the lock's `b_in`/`clear` serial interface.

## Interface
Parameters:
- CODE_W, 6: code length in bits; must be ≥ 1.
- MAX_TRY, 3: total attempts per start, including the first; must be ≥ 1.
- CHK_CYC, 2: CHECK-state cycles per attempt; must be ≥ 1.

Ports:
- clk  in  1  single clock; all keyer flops on posedge.
- clear  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- code  in  CODE_W  code word; latched on the accepted start edge.
- unlock  in  1  lock status from the receiver.
- b_out  out  1  serial bit to the lock's `b_in`.
- lock_clr_n  out  1  drives the lock's `clear` (active-low).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result; valid with `done`, held until the next accepted start.
- tries  out  $clog2(MAX_TRY+1)  attempts used by the current or last operation.

## Operation
- States: IDLE, CLR, SHIFT, CHECK, DONE.
- IDLE:
  - If start=1: latch `code` into the shift register, set tries←1, clear pass, go to CLR.
  - If start=0: stay in IDLE.
- CLR: one cycle. lock_clr_n=0, b_out=0. Next state is SHIFT with bit index CODE_W-1.
- SHIFT: CODE_W cycles.
  - b_out = latched code[idx], MSB first.
  - idx decrements each cycle; leave for CHECK after idx 0.
  - `unlock` is ignored in this state.
- CHECK: up to CHK_CYC cycles. b_out=0. `unlock` is sampled on each posedge.
  - unlock=1 → DONE with pass←1.
  - Last CHECK cycle ends with unlock=0 and tries<MAX_TRY → tries←tries+1, go to CLR.
  - Last CHECK cycle ends with unlock=0 and tries=MAX_TRY → DONE with pass←0.
- DONE: one cycle. done=1. Next state is IDLE.
- lock_clr_n is 0 only during reset and in CLR; it is 1 in every other state, so an unlocked lock stays visibly unlocked in IDLE.
- start while busy is ignored (not queued). Changes on `code` after latching are ignored.

## Timing
- Outputs change on posedge. The lock samples `b_in` on negedge, i.e. mid-bit.
- Reset values (clear=0, applied immediately): state=IDLE, b_out=0, lock_clr_n=0, busy=0, done=0, pass=0, tries=0, shift register=0.
- Reset asserted mid-operation aborts at once with no done pulse; lock_clr_n=0 holds the lock cleared.
- Cycle counting, start sampled at edge E0:
  - CLR is cycle 1; SHIFT is cycles 2..CODE_W+1; first CHECK cycle is CODE_W+2.
  - Pass on the first attempt: unlock sampled at edge E(CODE_W+2); done=1 in cycle CODE_W+3 (cycle 9 for the defaults).
  - Each failed attempt costs 1+CODE_W+CHK_CYC cycles (9 for the defaults).
  - Full fail: done in cycle MAX_TRY·(1+CODE_W+CHK_CYC)+1 (28 for the defaults).
- busy rises at E0+ and falls after the DONE cycle.
- start=1 in the DONE cycle is ignored. start=1 in the first IDLE cycle after DONE is accepted.
- tries saturates at MAX_TRY and never wraps.

## Structure
- Package `dlock_pkg`:
  - state enum (IDLE, CLR, SHIFT, CHECK, DONE)
  - DLOCK_CODE_W=6
  - DLOCK_CODE=6'b101100, the receiver's unlock code
- Sub-module `dlock_piso`: CODE_W parallel-in serial-out register with load, shift enable, and MSB output.
- The FSM, the CHECK counter and the tries counter live in `dlock_keyer`.

## Test plan
Bench connects `b_out`→`b_in` and `lock_clr_n`→`clear` of the team's `dlock` receiver, with the lock on negedge and the keyer on posedge.
- Correct code: code=6'b101100, start pulse → b_out sequence 1,0,1,1,0,0; done in cycle 9; pass=1; tries=1.
- Wrong code: code=6'b110100 → three attempts with lock_clr_n low in cycles 1, 10 and 19; done in cycle 28; pass=0; tries=3.
- Ignored requests: start held during busy, and code changed during SHIFT → no restart; transmitted bits equal the originally latched code.
- Mid-shift reset: clear=0 in cycle 4 → all outputs reach reset values immediately, lock_clr_n=0, no done pulse; a later start runs normally.
- Degenerate parameters: MAX_TRY=1, CHK_CYC=1 with code=6'b111111 → single attempt; done in cycle 9; pass=0.
- Back-to-back: start in the DONE cycle is ignored; start in the following IDLE cycle with code=6'b101100 → pass=1, and pass is cleared at the new start.

Source files
------------

// File: rtl/dlock_pkg.sv
// dlock_pkg: shared types and constants for the dlock keyer.
//   state_t      keyer FSM states
//   DLOCK_CODE_W code length of the dlock receiver
//   DLOCK_CODE   code that unlocks the dlock receiver
package dlock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DLOCK_CODE_W = 6;
  localparam logic [DLOCK_CODE_W-1:0] DLOCK_CODE = 6'b101100;

endpackage

// File: rtl/dlock_piso.sv
// dlock_piso: parallel-in serial-out register, MSB first.
//   clk    posedge clock
//   clear  asynchronous active-low reset (register cleared to 0)
//   load   load din (has priority over shift)
//   shift  advance one bit towards the MSB
//   din    parallel word
//   msb    current serial bit
module dlock_piso import dlock_pkg::*; #(
  parameter int CODE_W = DLOCK_CODE_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [CODE_W-1:0] din,
  output logic              msb
);

  logic [CODE_W-1:0] sreg;

  // Shifting rotates rather than discards: after CODE_W shifts the word is
  // back in place, so a retry can resend it without reloading the input.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= (sreg << 1) | (sreg >> (CODE_W - 1));
    end
  end

  assign msb = sreg[CODE_W-1];

endmodule

// File: rtl/dlock_keyer.sv
// dlock_keyer: serial code transmitter for the dlock receiver.
// Clears the lock, shifts the latched code out MSB-first, then watches
// unlock for CHK_CYC cycles, retrying up to MAX_TRY attempts in total.
//   clk         posedge clock
//   clear       asynchronous active-low reset
//   start       request pulse, honoured only in IDLE
//   code        code word, latched when start is accepted
//   unlock      lock status from the receiver
//   b_out       serial bit to the lock's b_in
//   lock_clr_n  active-low clear to the lock
//   busy        high whenever not IDLE
//   done        one-cycle completion pulse
//   pass        result, valid with done, held until the next start
//   tries       attempts used by the current or last operation
module dlock_keyer import dlock_pkg::*; #(
  parameter int CODE_W  = DLOCK_CODE_W,
  parameter int MAX_TRY = 3,
  parameter int CHK_CYC = 2
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         start,
  input  logic [CODE_W-1:0]            code,
  input  logic                         unlock,
  output logic                         b_out,
  output logic                         lock_clr_n,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(MAX_TRY+1)-1:0] tries
);

  localparam int TRY_W = $clog2(MAX_TRY + 1);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int CHK_W = (CHK_CYC > 1) ? $clog2(CHK_CYC) : 1;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CHK_W-1:0]   chk, chk_nx;
  logic [TRY_W-1:0]   tries_nx;
  logic               pass_nx;
  logic               load;
  logic               shift_en;
  logic               bit_msb;

  dlock_piso #(
    .CODE_W (CODE_W)
  ) u_piso (
    .clk   (clk),
    .clear (clear),
    .load  (load),
    .shift (shift_en),
    .din   (code),
    .msb   (bit_msb)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      idx   <= '0;
      chk   <= '0;
      tries <= '0;
      pass  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      chk   <= chk_nx;
      tries <= tries_nx;
      pass  <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    chk_nx   = chk;
    tries_nx = tries;
    pass_nx  = pass;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          tries_nx = TRY_W'(1);
          pass_nx  = 1'b0;
          state_nx = CLR;
        end
      end
      CLR: begin
        idx_nx   = IDX_W'(CODE_W - 1);
        state_nx = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (idx == '0) begin
          chk_nx   = '0;
          state_nx = CHECK;
        end else begin
          idx_nx = idx - IDX_W'(1);
        end
      end
      CHECK: begin
        if (unlock) begin
          pass_nx  = 1'b1;
          state_nx = DONE;
        end else if (chk == CHK_W'(CHK_CYC - 1)) begin
          // Increment only below MAX_TRY, so tries saturates there.
          if (tries < TRY_W'(MAX_TRY)) begin
            tries_nx = tries + TRY_W'(1);
            state_nx = CLR;
          end else begin
            pass_nx  = 1'b0;
            state_nx = DONE;
          end
        end else begin
          chk_nx = chk + CHK_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state, so they still change only on
  // posedge. lock_clr_n also follows clear directly so the lock is held
  // cleared for the whole reset, and goes high as soon as reset lifts.
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign b_out      = (state == SHIFT) && bit_msb;
  assign lock_clr_n = clear && (state != CLR);

endmodule

// File: tb/tb_dlock_keyer.sv
module tb_dlock_keyer;
  import dlock_pkg::*;

  localparam int W  = 6;
  localparam int MT = 3;
  localparam int CC = 2;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] code = '0;
  logic         unlock = 1'b0;
  logic         b_out, lock_clr_n, busy, done, pass;
  logic [1:0]   tries;

  logic         start2 = 1'b0;
  logic [W-1:0] code2 = '0;
  logic         unlock2 = 1'b0;
  logic         b_out2, lock_clr_n2, busy2, done2, pass2;
  logic [0:0]   tries2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlock_keyer #(.CODE_W(W), .MAX_TRY(MT), .CHK_CYC(CC)) dut (
    .clk(clk), .clear(clear), .start(start), .code(code), .unlock(unlock),
    .b_out(b_out), .lock_clr_n(lock_clr_n), .busy(busy), .done(done),
    .pass(pass), .tries(tries)
  );

  dlock_keyer #(.CODE_W(W), .MAX_TRY(1), .CHK_CYC(1)) dut2 (
    .clk(clk), .clear(clear), .start(start2), .code(code2), .unlock(unlock2),
    .b_out(b_out2), .lock_clr_n(lock_clr_n2), .busy(busy2), .done(done2),
    .pass(pass2), .tries(tries2)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Receiver stand-in: after a clear it takes the first W bits on negedge
  // and unlocks (until the next clear) if they equal DLOCK_CODE.
  int           lk_cnt = 0;
  logic [W-1:0] lk_bits = '0;
  initial forever begin
    @(negedge clk or negedge lock_clr_n);
    if (!lock_clr_n) begin
      lk_cnt = 0; lk_bits = '0; unlock = 1'b0;
    end else if (lk_cnt < W) begin
      lk_bits = {lk_bits[W-2:0], b_out};
      lk_cnt++;
      if (lk_cnt == W) unlock = (lk_bits == DLOCK_CODE);
    end
  end

  int           lk2_cnt = 0;
  logic [W-1:0] lk2_bits = '0;
  initial forever begin
    @(negedge clk or negedge lock_clr_n2);
    if (!lock_clr_n2) begin
      lk2_cnt = 0; lk2_bits = '0; unlock2 = 1'b0;
    end else if (lk2_cnt < W) begin
      lk2_bits = {lk2_bits[W-2:0], b_out2};
      lk2_cnt++;
      if (lk2_cnt == W) unlock2 = (lk2_bits == DLOCK_CODE);
    end
  end

  // Reference model: on an accepted start, the whole per-cycle output
  // timeline is written out from the operating rules into a queue.
  typedef struct packed {
    logic       idle;
    logic       b;
    logic       cn;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] tries;
  } exp_t;

  exp_t q[$];
  exp_t cur = '{idle:1'b1, b:1'b0, cn:1'b1, busy:1'b0, done:1'b0, pass:1'b0, tries:2'd0};

  task automatic build(input logic [W-1:0] c);
    exp_t e;
    q.delete();
    for (int k = 1; k <= MT; k++) begin
      e = '{idle:1'b0, b:1'b0, cn:1'b0, busy:1'b1, done:1'b0, pass:1'b0, tries:2'(k)};
      q.push_back(e);
      e.cn = 1'b1;
      for (int i = W - 1; i >= 0; i--) begin
        e.b = c[i];
        q.push_back(e);
      end
      e.b = 1'b0;
      if (c == DLOCK_CODE) begin
        q.push_back(e);
        e.done = 1'b1; e.pass = 1'b1;
        q.push_back(e);
        return;
      end
      for (int j = 0; j < CC; j++) q.push_back(e);
    end
    e.done = 1'b1; e.pass = 1'b0; e.tries = 2'(MT);
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk or negedge clear);
    if (!clear) begin
      q.delete();
      cur = '{idle:1'b1, b:1'b0, cn:1'b1, busy:1'b0, done:1'b0, pass:1'b0, tries:2'd0};
    end else if (cur.idle && start) begin
      build(code);
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur.idle = 1'b1; cur.b = 1'b0; cur.cn = 1'b1; cur.busy = 1'b0; cur.done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("b_out",      8'(b_out),      8'(cur.b));
    chk("lock_clr_n", 8'(lock_clr_n), 8'(cur.cn & clear));
    chk("busy",       8'(busy),       8'(cur.busy));
    chk("done",       8'(done),       8'(cur.done));
    chk("pass",       8'(pass),       8'(cur.pass));
    chk("tries",      8'(tries),      8'(cur.tries));
  end

  logic       ob_b[0:40], ob_cn[0:40], ob_busy[0:40], ob_done[0:40], ob_pass[0:40];
  logic [1:0] ob_tries[0:40];

  task automatic kick(input logic [W-1:0] c);
    @(negedge clk);
    code  = c;
    start = 1'b1;
  endtask

  // Cycle k (1-based after the start edge) is recorded at its negedge;
  // start is then set for the edge that ends cycle k.
  task automatic observe(input int n, input int s_lo, input int s_hi, input int chg_k);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ob_b[k] = b_out; ob_cn[k] = lock_clr_n; ob_busy[k] = busy;
      ob_done[k] = done; ob_pass[k] = pass; ob_tries[k] = tries;
      start = (k >= s_lo && k <= s_hi);
      if (k == chg_k) code = ~code;
    end
  endtask

  function automatic logic [W-1:0] tx_seq();
    logic [W-1:0] s = '0;
    for (int k = 2; k <= W + 1; k++) s = {s[W-2:0], ob_b[k]};
    return s;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (ob_done[k]) c++;
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         lows;
    logic       d_done[0:12], d_cn[0:12], d_busy[0:12], d_pass[0:12];
    logic [0:0] d_tries[0:12];

    repeat (3) @(negedge clk);
    chk("rst_b_out", 8'(b_out), 8'd0);
    chk("rst_lock_clr_n", 8'(lock_clr_n), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_tries", 8'(tries), 8'd0);
    clear = 1'b1;
    @(negedge clk);

    // correct code, first-attempt pass
    kick(DLOCK_CODE);
    observe(12, 0, -1, 0);
    chk("ok_seq", 8'(tx_seq()), 8'(6'b101100));
    chk("ok_clr_c1", 8'(ob_cn[1]), 8'd0);
    chk("ok_done_c8", 8'(ob_done[8]), 8'd0);
    chk("ok_done_c9", 8'(ob_done[9]), 8'd1);
    chk("ok_pass", 8'(ob_pass[9]), 8'd1);
    chk("ok_tries", 8'(ob_tries[9]), 8'd1);
    chk("ok_busy_c10", 8'(ob_busy[10]), 8'd0);

    // wrong code, three attempts
    kick(6'b110100);
    observe(30, 0, -1, 0);
    lows = 0;
    for (int k = 1; k <= 30; k++) if (!ob_cn[k]) lows++;
    chk("bad_clr_lows", 8'(lows), 8'd3);
    chk("bad_clr_c10", 8'(ob_cn[10]), 8'd0);
    chk("bad_clr_c19", 8'(ob_cn[19]), 8'd0);
    chk("bad_done_c28", 8'(ob_done[28]), 8'd1);
    chk("bad_done_cnt", 8'(count_done(30)), 8'd1);
    chk("bad_pass", 8'(ob_pass[28]), 8'd0);
    chk("bad_tries", 8'(ob_tries[28]), 8'd3);

    // start held while busy, code flipped during SHIFT
    kick(DLOCK_CODE);
    observe(12, 1, 8, 3);
    chk("ign_seq", 8'(tx_seq()), 8'(6'b101100));
    chk("ign_done_c9", 8'(ob_done[9]), 8'd1);
    chk("ign_busy_c10", 8'(ob_busy[10]), 8'd0);

    // back-to-back: start in DONE ignored, start in next IDLE accepted
    kick(DLOCK_CODE);
    observe(22, 9, 10, 0);
    chk("b2b_busy_c10", 8'(ob_busy[10]), 8'd0);
    chk("b2b_pass_c10", 8'(ob_pass[10]), 8'd1);
    chk("b2b_busy_c11", 8'(ob_busy[11]), 8'd1);
    chk("b2b_pass_c11", 8'(ob_pass[11]), 8'd0);
    chk("b2b_clr_c11", 8'(ob_cn[11]), 8'd0);
    chk("b2b_done_c19", 8'(ob_done[19]), 8'd1);
    chk("b2b_pass_c19", 8'(ob_pass[19]), 8'd1);
    chk("b2b_done_cnt", 8'(count_done(22)), 8'd2);

    // reset in cycle 4 (mid-shift)
    kick(DLOCK_CODE);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    chk("mrst_b_out", 8'(b_out), 8'd0);
    chk("mrst_lock_clr_n", 8'(lock_clr_n), 8'd0);
    chk("mrst_busy", 8'(busy), 8'd0);
    chk("mrst_done", 8'(done), 8'd0);
    chk("mrst_pass", 8'(pass), 8'd0);
    chk("mrst_tries", 8'(tries), 8'd0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    kick(DLOCK_CODE);
    observe(10, 0, -1, 0);
    chk("post_rst_done", 8'(ob_done[9]), 8'd1);
    chk("post_rst_pass", 8'(ob_pass[9]), 8'd1);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if (start) code = ($urandom_range(0, 1) == 1) ? DLOCK_CODE : W'($urandom);
      else if ($urandom_range(0, 15) == 0) code = W'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);

    // degenerate parameters: one attempt, one CHECK cycle
    @(negedge clk); code2 = 6'b111111; start2 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      d_done[k] = done2; d_cn[k] = lock_clr_n2; d_busy[k] = busy2;
      d_pass[k] = pass2; d_tries[k] = tries2;
    end
    lows = 0;
    for (int k = 1; k <= 12; k++) if (!d_cn[k]) lows++;
    chk("deg_clr_c1", 8'(d_cn[1]), 8'd0);
    chk("deg_clr_lows", 8'(lows), 8'd1);
    chk("deg_busy_c8", 8'(d_busy[8]), 8'd1);
    chk("deg_done_c9", 8'(d_done[9]), 8'd1);
    chk("deg_done_c8", 8'(d_done[8]), 8'd0);
    chk("deg_pass", 8'(d_pass[9]), 8'd0);
    chk("deg_tries", 8'(d_tries[9]), 8'd1);
    chk("deg_busy_c10", 8'(d_busy[10]), 8'd0);

    @(negedge clk); code2 = DLOCK_CODE; start2 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      d_done[k] = done2; d_pass[k] = pass2;
    end
    chk("deg_ok_done_c9", 8'(d_done[9]), 8'd1);
    chk("deg_ok_pass", 8'(d_pass[9]), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
